// File: rtl/kgd_fill_master.sv
// Wishbone master that fills KGD video memory via its control/data/address registers.
// Optional read-back check of every byte is compiled in with KGD_FILL_VERIFY_EN.
module kgd_fill_master #(
  parameter logic [2:0]  BASE    = 3'o0,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_start_i,
  input  logic [13:0] cmd_addr_i,
  input  logic [14:0] cmd_len_i,
  input  logic [7:0]  cmd_data_i,
  input  logic [7:0]  cmd_step_i,
  input  logic [1:0]  cmd_gmode_i,
  input  logic        cmd_setmode_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i
);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

`ifdef KGD_FILL_VERIFY_EN
  typedef enum logic [2:0] {IDLE, MODE, ADDR, DATA, VERIFY, NEXT, GAPW, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, MODE, ADDR, DATA, NEXT, GAPW, FIN} state_t;
`endif

  state_t      state_q, state_d, after_q, after_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d, step_q, step_d;
  logic [1:0]  gmode_q, gmode_d;
  logic [14:0] rem_q, rem_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        busy_d, done_d, err_d, cyc_d, stb_d, we_d;
  logic [2:0]  adr_d;
  logic [15:0] dat_d;
  logic [1:0]  sel_d;
  logic        xfer_end, timed_out;

`ifdef KGD_FILL_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^wb_dat_i[15:8];
`else
  logic unused_rd;
  assign unused_rd = ^wb_dat_i;
`endif

  assign xfer_end  = wb_stb_o & wb_ack_i;
  assign timed_out = wb_stb_o & ~wb_ack_i & (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;  after_d = after_q;
    addr_d  = addr_q;   data_d  = data_q;  step_d = step_q;
    gmode_d = gmode_q;  rem_d   = rem_q;   gcnt_d = gcnt_q;
    tcnt_d  = wb_stb_o ? tcnt_q + TW'(1) : tcnt_q;
    busy_d  = busy_o;   done_d  = 1'b0;    err_d  = err_o;
    cyc_d   = wb_cyc_o; stb_d   = wb_stb_o; we_d  = wb_we_o;
    adr_d   = wb_adr_o; dat_d   = wb_dat_o; sel_d = wb_sel_o;

    case (state_q)
      IDLE: if (cmd_start_i) begin
        addr_d  = cmd_addr_i;  data_d = cmd_data_i; step_d = cmd_step_i;
        gmode_d = cmd_gmode_i; rem_d  = cmd_len_i;
        err_d   = 1'b0;        busy_d = 1'b1;
        if (cmd_setmode_i)        state_d = MODE;
        else if (cmd_len_i == '0) state_d = FIN;
        else                      state_d = ADDR;
      end
      MODE: if (xfer_end) begin
        after_d = (rem_q == '0) ? FIN : ADDR;
        state_d = GAPW;  gcnt_d = GW'(GAP);
      end
      ADDR: if (xfer_end) begin
        after_d = DATA;  state_d = GAPW;  gcnt_d = GW'(GAP);
      end
`ifdef KGD_FILL_VERIFY_EN
      DATA: if (xfer_end) begin
        after_d = VERIFY;  state_d = GAPW;  gcnt_d = GW'(GAP);
      end
      VERIFY: if (xfer_end) begin
        if (wb_dat_i[7:0] != data_q) err_d = 1'b1;
        state_d = NEXT;
      end
`else
      DATA: if (xfer_end) state_d = NEXT;
`endif
      // NEXT doubles as the first idle cycle, so GAPW only covers the rest of the gap
      NEXT: begin
        addr_d  = addr_q + 14'd1;
        data_d  = data_q + step_q;
        rem_d   = rem_q - 15'd1;
        after_d = (rem_q == 15'd1) ? FIN : ADDR;
        state_d = GAPW;
        gcnt_d  = GW'(GAP - 1);
      end
      GAPW: if (gcnt_q <= GW'(1)) state_d = after_q;
            else gcnt_d = gcnt_q - GW'(1);
      FIN: begin
        done_d = 1'b1;  busy_d = 1'b0;  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timed_out) begin
      state_d = FIN;  err_d = 1'b1;
    end
    if (xfer_end || timed_out) begin
      cyc_d = 1'b0;  stb_d = 1'b0;  we_d = 1'b0;
    end

    // Bus registers are loaded on the edge that enters a bus state, using the
    // freshly latched command values when coming straight from IDLE.
    if (state_d != state_q) begin
      case (state_d)
        MODE: begin
          cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; tcnt_d = '0;
          adr_d = BASE; dat_d = {gmode_d, 14'b0}; sel_d = 2'b10;
        end
        ADDR: begin
          cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; tcnt_d = '0;
          adr_d = BASE + 3'd4; dat_d = {2'b0, addr_d}; sel_d = 2'b11;
        end
        DATA: begin
          cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1; tcnt_d = '0;
          adr_d = BASE + 3'd2; dat_d = {8'h00, data_d}; sel_d = 2'b01;
        end
`ifdef KGD_FILL_VERIFY_EN
        VERIFY: begin
          cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b0; tcnt_d = '0;
          adr_d = BASE + 3'd2; sel_d = 2'b11;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;  after_q <= IDLE;
      addr_q   <= '0;    data_q  <= '0;  step_q <= '0;
      gmode_q  <= '0;    rem_q   <= '0;  gcnt_q <= '0;  tcnt_q <= '0;
      busy_o   <= 1'b0;  done_o  <= 1'b0; err_o <= 1'b0;
      wb_cyc_o <= 1'b0;  wb_stb_o <= 1'b0; wb_we_o <= 1'b0;
      wb_adr_o <= '0;    wb_dat_o <= '0;   wb_sel_o <= 2'b00;
    end else begin
      state_q  <= state_d;  after_q <= after_d;
      addr_q   <= addr_d;   data_q  <= data_d;  step_q <= step_d;
      gmode_q  <= gmode_d;  rem_q   <= rem_d;   gcnt_q <= gcnt_d;  tcnt_q <= tcnt_d;
      busy_o   <= busy_d;   done_o  <= done_d;  err_o  <= err_d;
      wb_cyc_o <= cyc_d;    wb_stb_o <= stb_d;  wb_we_o <= we_d;
      wb_adr_o <= adr_d;    wb_dat_o <= dat_d;  wb_sel_o <= sel_d;
    end
  end
endmodule

// File: tb/tb_kgd_fill_master.sv
// Directed bench for kgd_fill_master with a behavioural KGD register-block slave.
module tb_kgd_fill_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start, cmd_setmode;
  logic [13:0] cmd_addr;
  logic [14:0] cmd_len;
  logic [7:0]  cmd_data, cmd_step;
  logic [1:0]  cmd_gmode;
  logic        busy, done, err;
  logic [2:0]  wb_adr;
  logic [15:0] wb_dat_w, wb_dat_r;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [1:0]  wb_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kgd_fill_master dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_start_i(cmd_start), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .cmd_data_i(cmd_data), .cmd_step_i(cmd_step), .cmd_gmode_i(cmd_gmode),
    .cmd_setmode_i(cmd_setmode),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_w), .wb_dat_i(wb_dat_r),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_sel_o(wb_sel), .wb_ack_i(wb_ack)
  );

  // KGD slave: ack is raised after two strobe cycles and held for two cycles.
  logic [7:0]  mem [0:16383];
  logic [13:0] kaddr;
  logic [1:0]  ctrl;
  int          phase;
  logic        no_ack, corrupt_en;
  logic [13:0] corrupt_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0; wb_ack <= 1'b0;
    end else begin
      case (phase)
        0: if (wb_cyc && wb_stb && !no_ack) phase <= 1;
        1: begin
          phase <= 2; wb_ack <= 1'b1;
          if (wb_we) begin
            case (wb_adr)
              3'd0: if (wb_sel[1]) ctrl <= wb_dat_w[15:14];
              3'd2: mem[kaddr] <= wb_dat_w[7:0];
              3'd4: kaddr <= wb_dat_w[13:0];
              default: ;
            endcase
          end
        end
        2: phase <= 3;
        default: begin phase <= 0; wb_ack <= 1'b0; end
      endcase
    end
  end

  assign wb_dat_r = {8'h00, (corrupt_en && kaddr == corrupt_addr) ? ~mem[kaddr] : mem[kaddr]};

  // Bus monitor
  int          stb_cycles = 0;
  int          done_cnt = 0;
  int          mode_cnt = 0;
  logic [15:0] mode_dat;
  logic [1:0]  mode_sel;
  logic [15:0] addr_log [$];

  always @(negedge clk) begin
    if (wb_stb) stb_cycles <= stb_cycles + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (wb_cyc && wb_stb && wb_ack && wb_we) begin
      if (wb_adr == 3'd4) addr_log.push_back(wb_dat_w);
      if (wb_adr == 3'd0) begin
        mode_cnt <= mode_cnt + 1; mode_dat <= wb_dat_w; mode_sel <= wb_sel;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_cmd(input logic [13:0] a, input logic [14:0] l, input logic [7:0] d,
                           input logic [7:0] s, input logic [1:0] gm, input logic sm);
    cmd_addr = a; cmd_len = l; cmd_data = d; cmd_step = s;
    cmd_gmode = gm; cmd_setmode = sm; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  // Returns the cycle index (start cycle = 0) at which done is seen, or limit.
  task automatic run_to_done(input int limit, output int n);
    n = 1;
    while (!done && n < limit) begin
      tick(); n++;
    end
  endtask

  int n, s0, d0, k0, m0;
  logic [7:0] expb;

  initial begin
    rst_n = 1'b0; cmd_start = 1'b0; cmd_setmode = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_data = '0; cmd_step = '0; cmd_gmode = '0;
    no_ack = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
    tick(); tick();
    check("rst_busy", busy, 0);   check("rst_done", done, 0);  check("rst_err", err, 0);
    check("rst_cyc", wb_cyc, 0);  check("rst_stb", wb_stb, 0); check("rst_we", wb_we, 0);
    check("rst_adr", wb_adr, 0);  check("rst_dat", wb_dat_w, 0); check("rst_sel", wb_sel, 0);
    rst_n = 1'b1;
    tick(); tick();

    // Basic fill; command inputs changed after acceptance must not matter
    d0 = done_cnt;
    start_cmd(14'd100, 15'd3, 8'hAA, 8'd1, 2'b00, 1'b0);
    cmd_data = 8'h00; cmd_addr = 14'd9;
    check("fill_first_stb", wb_stb, 1);
    check("fill_first_adr", wb_adr, 3'd4);
    check("fill_first_dat", wb_dat_w, 16'd100);
    check("fill_first_sel", wb_sel, 2'b11);
    check("fill_busy", busy, 1);
    run_to_done(100, n);
    check("fill_done", done, 1);
    check("fill_done_cycle", n, 32);
    check("fill_busy_end", busy, 0);
    check("fill_err", err, 0);
    tick();
    check("fill_done_pulse", done, 0);
    check("fill_done_cnt", done_cnt - d0, 1);
    check("fill_m100", mem[100], 8'hAA);
    check("fill_m101", mem[101], 8'hAB);
    check("fill_m102", mem[102], 8'hAC);

    // Address wrap
    k0 = addr_log.size();
    start_cmd(14'd16383, 15'd2, 8'h55, 8'd0, 2'b00, 1'b0);
    run_to_done(100, n);
    check("wrap_done", done, 1);
    check("wrap_m16383", mem[16383], 8'h55);
    check("wrap_m0", mem[0], 8'h55);
    check("wrap_log_len", addr_log.size() - k0, 2);
    if (addr_log.size() >= k0 + 2) begin
      check("wrap_adr0", addr_log[k0], 16'h3FFF);
      check("wrap_adr1", addr_log[k0 + 1], 16'h0000);
    end
    tick();

    // Mode write with zero length
    m0 = mode_cnt; s0 = stb_cycles;
    start_cmd(14'd5, 15'd0, 8'h00, 8'd0, 2'b11, 1'b1);
    run_to_done(50, n);
    check("mode_done", done, 1);
    check("mode_done_cycle", n, 7);
    tick();
    check("mode_cnt", mode_cnt - m0, 1);
    check("mode_dat", mode_dat, 16'hC000);
    check("mode_sel", mode_sel, 2'b10);
    check("mode_genable", ctrl[1], 1);
    check("mode_tdisable", ctrl[0], 1);
    check("mode_stb_cycles", stb_cycles - s0, 3);

    // Zero length, no mode: no bus activity
    s0 = stb_cycles;
    start_cmd(14'd5, 15'd0, 8'h00, 8'd0, 2'b00, 1'b0);
    run_to_done(20, n);
    check("noop_done", done, 1);
    check("noop_done_cycle", n, 2);
    tick();
    check("noop_stb", stb_cycles - s0, 0);

    // Timeout
    no_ack = 1'b1;
    s0 = stb_cycles; d0 = done_cnt;
    start_cmd(14'd50, 15'd1, 8'h11, 8'd0, 2'b00, 1'b0);
    run_to_done(400, n);
    check("to_done", done, 1);
    check("to_done_cycle", n, 257);
    check("to_err", err, 1);
    tick();
    check("to_stb_cycles", stb_cycles - s0, 255);
    check("to_done_cnt", done_cnt - d0, 1);
    s0 = stb_cycles;
    repeat (20) tick();
    check("to_no_more_stb", stb_cycles - s0, 0);
    no_ack = 1'b0;

    // Next accepted start clears err
    start_cmd(14'd60, 15'd1, 8'h77, 8'd0, 2'b00, 1'b0);
    check("errclr_err", err, 0);
    run_to_done(50, n);
    check("errclr_done_cycle", n, 12);
    check("errclr_m60", mem[60], 8'h77);
    tick();

    // Reset during a DATA strobe
    start_cmd(14'd300, 15'd3, 8'h01, 8'd1, 2'b00, 1'b0);
    n = 0;
    while (!(wb_stb && wb_adr == 3'd2) && n < 50) begin tick(); n++; end
    check("rstmid_found", wb_stb && wb_adr == 3'd2, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_cyc", wb_cyc, 0);
    check("rstmid_stb", wb_stb, 0);
    check("rstmid_busy", busy, 0);
    d0 = done_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) tick();
    check("rstmid_no_done", done_cnt - d0, 0);
    start_cmd(14'd7, 15'd1, 8'h3C, 8'd0, 2'b00, 1'b0);
    run_to_done(50, n);
    check("rstmid_after_done", done, 1);
    check("rstmid_after_cycle", n, 12);
    check("rstmid_after_m7", mem[7], 8'h3C);
    check("rstmid_after_err", err, 0);
    tick();

`ifdef KGD_FILL_VERIFY_EN
    // Read-back check with byte 5 corrupted by the slave
    corrupt_en = 1'b1; corrupt_addr = 14'd205;
    d0 = done_cnt;
    start_cmd(14'd200, 15'd8, 8'h10, 8'd3, 2'b00, 1'b0);
    run_to_done(300, n);
    check("vfy_done", done, 1);
    check("vfy_done_cycle", n, 122);
    check("vfy_err", err, 1);
    tick();
    check("vfy_done_cnt", done_cnt - d0, 1);
    expb = 8'h10;
    for (int i = 0; i < 8; i++) begin
      check("vfy_mem", mem[200 + i], expb);
      expb = expb + 8'd3;
    end
    corrupt_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
